// File: rtl/generic_adder.sv
// ----------------------------------------------------------------------------
// generic_adder
//
// Purpose:
//   Registered WIDTH-bit ripple-carry adder built from per-bit full-adder
//   cells.  Computes {carry, sum} = ain + bin + cin with one clock of latency
//   and exposes the registered internal carry chain on c.  A new operation
//   is accepted on every rising clock edge; there is no enable or handshake.
//
// Parameters:
//   WIDTH  operand / sum width, 1..64 (default 24)
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset, clears all outputs
//   sum    out  WIDTH    registered sum, modulo 2^WIDTH
//   carry  out  1        registered carry-out of the MSB cell
//   ain    in   WIDTH    operand A, unsigned
//   bin    in   WIDTH    operand B, unsigned
//   cin    in   1        carry-in to bit 0
//   c      out  WIDTH+1  registered carry chain; c[0] = cin, c[WIDTH] = carry
//   ovf    out  1        registered two's-complement overflow
//                        (present only when GENERIC_ADDER_OVF_EN is defined)
//
// Configuration macro:
//   GENERIC_ADDER_OVF_EN  adds the ovf output and its register.
// ----------------------------------------------------------------------------
module generic_adder #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    output logic [WIDTH:0]   c
`ifdef GENERIC_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Combinational carry chain and per-bit sum.
    logic [WIDTH:0]   k_s;
    logic [WIDTH-1:0] s_s;

    // Output registers.
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [WIDTH:0]   c_r;

    assign k_s[0] = cin;

    // One full-adder cell per bit, rippled through k_s.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic p_s;
        assign p_s        = ain[i] ^ bin[i];
        assign s_s[i]     = p_s ^ k_s[i];
        assign k_s[i + 1] = (ain[i] & bin[i]) | (k_s[i] & p_s);
    end

    // Register sum, carry-out and full carry chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            c_r     <= {(WIDTH + 1){1'b0}};
        end else begin
            sum_r   <= s_s;
            carry_r <= k_s[WIDTH];
            c_r     <= k_s;
        end
    end

    assign sum   = sum_r;
    assign carry = carry_r;
    assign c     = c_r;

`ifdef GENERIC_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    logic ovf_s;
    logic ovf_r;

    assign ovf_s = k_s[WIDTH] ^ k_s[WIDTH-1];

    // Register overflow alongside the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_s;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_generic_adder.sv
// ----------------------------------------------------------------------------
// tb_generic_adder
//
// Self-checking bench for generic_adder at WIDTH = 24.  Expected results are
// computed arithmetically from the applied operands, pushed to a scoreboard
// queue when the operands are driven and popped after the sampling edge.
// Define GENERIC_ADDER_OVF_EN for both files to also check ovf.
// ----------------------------------------------------------------------------
module tb_generic_adder;

    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic [W:0]   c;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sum;
    logic         carry;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic         cin;
    logic [W:0]   c;
`ifdef GENERIC_ADDER_OVF_EN
    logic         ovf;
`endif

    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    generic_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sum   (sum),
        .carry (carry),
        .ain   (ain),
        .bin   (bin),
        .cin   (cin),
        .c     (c)
`ifdef GENERIC_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: c[i] is bit i of the sum of the low i bits of each operand
    // plus cin, i.e. the carry into bit i.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci);
        exp_t        e;
        logic [W:0]  full;
        logic [W:0]  m;
        logic [W:0]  t;
        full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        e.c     = {(W + 1){1'b0}};
        e.c[0]  = ci;
        for (int i = 1; i <= W; i++) begin
            m      = ({{W{1'b0}}, 1'b1} << i) - {{W{1'b0}}, 1'b1};
            t      = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, ci};
            e.c[i] = t[i];
        end
        e.ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"},   64'(sum),   64'd0);
        chk({tag, ".carry"}, 64'(carry), 64'd0);
        chk({tag, ".c"},     64'(c),     64'd0);
`ifdef GENERIC_ADDER_OVF_EN
        chk({tag, ".ovf"},   64'(ovf),   64'd0);
`endif
    endtask

    // Drive one operation at the falling edge, then check after the next rise.
    task automatic step(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
        exp_t e;
        @(negedge clk);
        ain = a;
        bin = b;
        cin = ci;
        sb_q.push_back(model(a, b, ci));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".sum"},   64'(sum),   64'(e.sum));
            chk({tag, ".carry"}, 64'(carry), 64'(e.carry));
            chk({tag, ".c"},     64'(c),     64'(e.c));
`ifdef GENERIC_ADDER_OVF_EN
            chk({tag, ".ovf"},   64'(ovf),   64'(e.ovf));
`endif
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        ain         = 24'h123456;
        bin         = 24'hFEDCBA;
        cin         = 1'b1;

        // Outputs held at zero while reset is low, even across clock edges.
        #1;
        chk_zero("rst_start");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("rst_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including the specified 24-bit vectors.
        step("zero",      24'h000000, 24'h000000, 1'b0);
        step("mixed",     24'h000005, 24'h00000A, 1'b1);
        step("ripple",    24'hFFFFFF, 24'h000001, 1'b0);
        step("ripple_ci", 24'hFFFFFF, 24'h000000, 1'b1);
        step("max_all",   24'hFFFFFF, 24'hFFFFFF, 1'b1);
        step("pos_ovf",   24'h7FFFFF, 24'h000001, 1'b0);
        step("neg_ovf",   24'h800000, 24'h800000, 1'b0);
        step("alt",       24'hAAAAAA, 24'h555555, 1'b1);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        step("pre_rst",   24'h00F0F0, 24'h0F0F0F, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        ain = 24'hFFFFFF;
        bin = 24'hFFFFFF;
        cin = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_discard");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running counters: cin every cycle, bin every 2, ain every 4.
        for (int n = 0; n < 32; n++) begin
            step("count", 24'hFFFFFC + 24'(n >> 2), 24'h7FFFF8 + 24'(n >> 1), n[0]);
        end

        // Random operands.
        for (int n = 0; n < 16; n++) begin
            step("rand", 24'($urandom), 24'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
